// File: rtl/dma_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dma_mc_ctrl
// Description : Multi-channel DMA engine. NUM_CH channels share one memory
//               master port through round-robin arbitration, each bus tenure
//               bounded to BURST_LEN words. Per-channel fixed or incrementing
//               source/destination addressing.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_mc_ctrl #(
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int SIZE_W    = 16,
    parameter int BURST_LEN = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          ch_start,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_src,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_dst,
    input  logic [NUM_CH*SIZE_W-1:0]   ch_size,
    input  logic [NUM_CH-1:0]          ch_src_inc,
    input  logic [NUM_CH-1:0]          ch_dst_inc,
    output logic [NUM_CH-1:0]          ch_busy,
    output logic [NUM_CH-1:0]          ch_done,
    output logic                       bus_request,
    input  logic                       bus_grant,
    output logic [ADDR_W-1:0]          addr_out,
    output logic [DATA_W-1:0]          data_out,
    input  logic [DATA_W-1:0]          data_in,
    output logic                       mem_read,
    output logic                       mem_write,
    input  logic                       mem_ready
);

    localparam int c_CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_TEN_W = $clog2(BURST_LEN + 1);
    localparam logic [ADDR_W-1:0] c_STEP = ADDR_W'(DATA_W / 8);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_REQ   = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4,
        S_NEXT  = 3'd5,
        S_REL   = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t              r_state;
    logic [c_CH_W-1:0]   r_rr;
    logic [c_CH_W-1:0]   r_ch;
    logic [c_TEN_W-1:0]  r_tenure;
    logic [NUM_CH-1:0]   r_busy;
    logic [NUM_CH-1:0]   r_done;
    logic [NUM_CH-1:0]   r_src_inc;
    logic [NUM_CH-1:0]   r_dst_inc;
    logic [ADDR_W-1:0]   r_src [NUM_CH];
    logic [ADDR_W-1:0]   r_dst [NUM_CH];
    logic [SIZE_W-1:0]   r_rem [NUM_CH];
    logic                r_bus_req;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;

    logic [c_CH_W-1:0]   w_pick;
    int                  w_idx;
    logic [SIZE_W-1:0]   w_rem_dec;
    logic [ADDR_W-1:0]   w_src_nxt;
    logic [ADDR_W-1:0]   w_dst_nxt;
    logic [c_TEN_W-1:0]  w_ten_nxt;
    logic [c_CH_W-1:0]   w_rr_nxt;

    assign ch_busy     = r_busy;
    assign ch_done     = r_done;
    assign bus_request = r_bus_req;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign addr_out    = r_addr;
    assign data_out    = r_data;

    // Round-robin pick: first busy channel at or after the RR pointer.
    // Scanning downward lets the smallest offset overwrite the others.
    always_comb begin
        w_pick = r_rr;
        w_idx  = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_idx = (int'(r_rr) + k) % NUM_CH;
            if (r_busy[c_CH_W'(w_idx)]) begin
                w_pick = c_CH_W'(w_idx);
            end
        end
    end

    // Per-word progress of the channel currently owning the bus.
    always_comb begin
        w_rem_dec = r_rem[r_ch] - SIZE_W'(1);
        w_src_nxt = r_src[r_ch] + (r_src_inc[r_ch] ? c_STEP : '0);
        w_dst_nxt = r_dst[r_ch] + (r_dst_inc[r_ch] ? c_STEP : '0);
        w_ten_nxt = r_tenure + c_TEN_W'(1);
        w_rr_nxt  = (r_ch == c_CH_W'(NUM_CH - 1)) ? '0 : r_ch + c_CH_W'(1);
    end

    // Channel registers, arbitration/transfer FSM and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr        <= '0;
            r_ch        <= '0;
            r_tenure    <= '0;
            r_busy      <= '0;
            r_done      <= '0;
            r_src_inc   <= '0;
            r_dst_inc   <= '0;
            r_bus_req   <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_src[i] <= '0;
                r_dst[i] <= '0;
                r_rem[i] <= '0;
            end
        end else begin
            r_done <= '0;

            // Accept starts only on idle channels; a zero-length job just
            // reports completion without ever becoming busy.
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_start[i] && !r_busy[i]) begin
                    if (ch_size[i*SIZE_W +: SIZE_W] == '0) begin
                        r_done[i] <= 1'b1;
                    end else begin
                        r_busy[i]    <= 1'b1;
                        r_src[i]     <= ch_src[i*ADDR_W +: ADDR_W];
                        r_dst[i]     <= ch_dst[i*ADDR_W +: ADDR_W];
                        r_rem[i]     <= ch_size[i*SIZE_W +: SIZE_W];
                        r_src_inc[i] <= ch_src_inc[i];
                        r_dst_inc[i] <= ch_dst_inc[i];
                    end
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (|r_busy) begin
                        r_state <= S_ARB;
                    end
                end
                S_ARB: begin
                    r_ch      <= w_pick;
                    r_tenure  <= '0;
                    r_bus_req <= 1'b1;
                    r_state   <= S_REQ;
                end
                S_REQ: begin
                    if (bus_grant) begin
                        r_mem_read <= 1'b1;
                        r_addr     <= r_src[r_ch];
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    if (mem_ready) begin
                        r_data      <= data_in;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b1;
                        r_addr      <= r_dst[r_ch];
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        r_mem_write <= 1'b0;
                        r_state     <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    r_rem[r_ch] <= w_rem_dec;
                    r_src[r_ch] <= w_src_nxt;
                    r_dst[r_ch] <= w_dst_nxt;
                    r_tenure    <= w_ten_nxt;
                    if (w_rem_dec == '0) begin
                        r_bus_req <= 1'b0;
                        r_state   <= S_DONE;
                    end else if ((w_ten_nxt == c_TEN_W'(BURST_LEN)) || !bus_grant) begin
                        // Tenure exhausted or grant withdrawn: hand the bus back,
                        // progress stays in the channel registers.
                        r_bus_req <= 1'b0;
                        r_state   <= S_REL;
                    end else begin
                        r_mem_read <= 1'b1;
                        r_addr     <= w_src_nxt;
                        r_state    <= S_READ;
                    end
                end
                S_REL: begin
                    r_rr    <= w_rr_nxt;
                    r_state <= S_IDLE;
                end
                S_DONE: begin
                    r_done[r_ch] <= 1'b1;
                    r_busy[r_ch] <= 1'b0;
                    r_rr         <= w_rr_nxt;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
